md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide unit for the pipelined MIPS core. It accepts one operation per launch and holds busy for a fixed latency, then commits results to the HI/LO registers. It also raises the stall request that the hazard logic routes into the stall inputs of the IF/ID and ID/EX pipeline registers. It sits in the EX stage, in parallel with the ALU; the consumers of its stall request are the pipeline registers.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  launch strobe from EX; qualified by op
- op  in  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, others=no-op
- a  in  32  rs operand (forwarded value)
- b  in  32  rt operand (forwarded value)
- md_use  in  1  instruction in ID is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in progress
- stall_req  out  1  combinational: md_use & (busy | (start & op≤3))
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset (rst high at a clk edge): busy=0, hi=0, lo=0, counter=0, pending results cleared. stall_req follows its equation with busy=0.
- Launch (start=1, busy=0, op 0–3):
  - Operands latched and result computed into pending_hi/pending_lo.
  - Counter loaded with MULT_CYCLES or DIV_CYCLES; busy=1 next cycle.
- Arithmetic:
  - mult: signed 32×32 → 64, hi=[63:32], lo=[31:0].
  - multu: unsigned 32×32 → 64, same split.
  - div: lo=quotient truncated toward zero; hi=remainder with sign of dividend (a).
  - divu: unsigned quotient/remainder.
- Divide by zero (b=0, op 2/3): full busy period runs; hi/lo unchanged at commit.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF, div): lo=0x80000000, hi=0.
- Countdown: counter decrements each busy cycle. When it reaches 1, pending values are written to hi/lo at that edge, busy=0 next cycle.
- mthi/mtlo (start=1, busy=0): hi←a or lo←a at the same edge; busy stays 0.
- Ignored inputs:
  - start while busy: ignored entirely (no relaunch, no mthi/mtlo). The hazard unit keeps this from happening; the bench checks it anyway.
  - op 6–7: no-op.
- mfhi/mflo read hi/lo directly; they are held off by stall_req while busy.

## Timing
- Launch edge at cycle T: busy=1 on cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES).
- Commit edge: hi/lo take their new values at the edge closing cycle T+N and are visible from cycle T+N+1, when busy=0.
- Back-to-back: a new start is accepted in cycle T+N+1 at the earliest.
- stall_req is 1 in cycle T itself when md_use=1 (start term), and stays 1 through T+N if md_use holds.
- mthi/mtlo: single cycle; new value visible the cycle after the start edge.
- Reset mid-operation: operation aborted, busy=0 and hi=lo=0 the next cycle, no commit.
- rst and start in the same cycle: rst wins.

## Test plan
- Reset check: rst held 2 cycles → busy=0, hi=0, lo=0, stall_req=md_use&start.
- mult: start, op=0, a=0xFFFFFFFE (−2), b=3 →
  - busy high exactly 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFA;
  - multu with same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div: op=2, a=−7 (0xFFFFFFF9), b=2 →
  - busy 10 cycles;
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - divu a=7, b=0 → busy 10 cycles, hi/lo unchanged.
- Stall handshake: launch div with md_use=1 throughout → stall_req=1 from launch cycle through last busy cycle, 0 the following cycle. A start pulse (op=0) during busy leaves the result and busy length unaffected.
- mthi/mtlo: mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on consecutive cycles → hi/lo show the values one cycle after each edge, busy stays 0. mthi issued during busy is ignored.
- Reset mid-op: launch mult, assert rst in the 3rd busy cycle → busy=0, hi=lo=0 next cycle, no later commit.

Source files
------------

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
//
// Multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS
// core.  A launch latches the operands, computes the 64-bit result straight
// away into a pending HI/LO pair and then counts down a fixed latency.  The
// pending pair is copied into HI/LO on the last busy cycle.  mthi/mtlo write
// HI/LO directly in a single cycle.  The unit also produces the stall request
// that the hazard logic feeds to the IF/ID and ID/EX pipeline registers.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu   (>= 1)
//
// Ports:
//   clk        in   1   clock
//   rst        in   1   synchronous, active-high reset
//   start      in   1   launch strobe from EX, qualified by op
//   op         in   3   0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6,7=no-op
//   a          in  32   rs operand (forwarded)
//   b          in  32   rt operand (forwarded)
//   md_use     in   1   instruction in ID touches HI/LO or the unit
//   busy       out  1   operation in progress
//   stall_req  out  1   md_use & (busy | (start & op <= 3)), combinational
//   hi         out 32   HI register
//   lo         out 32   LO register
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pendHi;
    logic [31:0]      r_pendLo;
    logic             r_commit;

    logic             w_arithOp;
    logic             w_signedDiv;
    logic signed [63:0] w_prodS;
    logic [63:0]      w_prodU;
    logic [31:0]      w_aMag;
    logic [31:0]      w_bMag;
    logic [31:0]      w_divN;
    logic [31:0]      w_divD;
    logic [31:0]      w_qRaw;
    logic [31:0]      w_rRaw;
    logic [31:0]      w_quot;
    logic [31:0]      w_rem;
    logic [31:0]      w_resHi;
    logic [31:0]      w_resLo;
    logic             w_resValid;
    logic [CNT_W-1:0] w_load;

    // op 0..3 are the long-latency arithmetic operations
    assign w_arithOp   = ~op[2];
    assign w_signedDiv = (op == OP_DIV);

    // Both products are formed on 64-bit operands so no intermediate truncates
    assign w_prodS = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prodU = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes through the same unsigned divider and
    // fixes the signs afterwards.  0x80000000 / -1 falls out correctly: its
    // magnitude 0x80000000 divided by 1, negated, wraps back to 0x80000000.
    // A zero divisor is replaced by 1 only to keep the divider defined; that
    // result is never committed.
    assign w_aMag = a[31] ? (32'd0 - a) : a;
    assign w_bMag = b[31] ? (32'd0 - b) : b;
    assign w_divN = w_signedDiv ? w_aMag : a;
    assign w_divD = (b == 32'd0) ? 32'd1 : (w_signedDiv ? w_bMag : b);
    assign w_qRaw = w_divN / w_divD;
    assign w_rRaw = w_divN % w_divD;
    assign w_quot = (w_signedDiv && (a[31] ^ b[31])) ? (32'd0 - w_qRaw) : w_qRaw;
    assign w_rem  = (w_signedDiv && a[31])           ? (32'd0 - w_rRaw) : w_rRaw;

    // Select the pending result and latency for the operation being launched
    always_comb begin
        w_resHi    = 32'd0;
        w_resLo    = 32'd0;
        w_resValid = 1'b0;
        w_load     = MULT_LOAD;
        case (op)
            OP_MULT: begin
                w_resHi    = w_prodS[63:32];
                w_resLo    = w_prodS[31:0];
                w_resValid = 1'b1;
                w_load     = MULT_LOAD;
            end
            OP_MULTU: begin
                w_resHi    = w_prodU[63:32];
                w_resLo    = w_prodU[31:0];
                w_resValid = 1'b1;
                w_load     = MULT_LOAD;
            end
            OP_DIV, OP_DIVU: begin
                w_resHi    = w_rem;
                w_resLo    = w_quot;
                w_resValid = (b != 32'd0);
                w_load     = DIV_LOAD;
            end
            default: begin
                w_resValid = 1'b0;
            end
        endcase
    end

    // Launch / countdown / commit, plus the single-cycle HI/LO moves.
    // While busy every start is ignored, including mthi/mtlo.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_pendHi <= 32'd0;
            r_pendLo <= 32'd0;
            r_commit <= 1'b0;
        end else if (r_state == ST_BUSY) begin
            if (r_count == CNT_ONE) begin
                if (r_commit) begin
                    r_hi <= r_pendHi;
                    r_lo <= r_pendLo;
                end
                r_state  <= ST_IDLE;
                r_count  <= '0;
                r_commit <= 1'b0;
            end else begin
                r_count <= r_count - CNT_ONE;
            end
        end else if (start) begin
            if (w_arithOp) begin
                r_pendHi <= w_resHi;
                r_pendLo <= w_resLo;
                r_commit <= w_resValid;
                r_count  <= w_load;
                r_state  <= ST_BUSY;
            end else if (op == OP_MTHI) begin
                r_hi <= a;
            end else if (op == OP_MTLO) begin
                r_lo <= a;
            end
        end
    end

    assign busy      = (r_state == ST_BUSY);
    assign stall_req = md_use & (busy | (start & w_arithOp));
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
//
// Self-checking bench for md_unit.  Expected HI/LO values come from a
// behavioural model using plain 64-bit arithmetic; expected busy length is
// the parameter latency.  Directed cases cover the documented examples,
// followed by a randomised run of mixed operations.
// ---------------------------------------------------------------------------
module tb_md_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int          nChecks;
    int          nPassed;
    logic [31:0] mHi;
    logic [31:0] mLo;

    md_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .md_use   (md_use),
        .busy     (busy),
        .stall_req(stall_req),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        if (observed === expected) begin
            nPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what HI/LO hold after an arithmetic op commits
    task automatic modelOp(input logic [2:0] opc, input logic [31:0] av,
                           input logic [31:0] bv, output logic [31:0] eHi,
                           output logic [31:0] eLo, output int n);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        sa  = longint'($signed(av));
        sb  = longint'($signed(bv));
        eHi = mHi;
        eLo = mLo;
        n   = (opc <= 3'd1) ? MULT_CYCLES : DIV_CYCLES;
        case (opc)
            3'd0: begin
                p   = 64'(sa * sb);
                eHi = p[63:32];
                eLo = p[31:0];
            end
            3'd1: begin
                p   = {32'd0, av} * {32'd0, bv};
                eHi = p[63:32];
                eLo = p[31:0];
            end
            3'd2: begin
                if (bv != 32'd0) begin
                    sq  = sa / sb;
                    sr  = sa % sb;
                    eLo = sq[31:0];
                    eHi = sr[31:0];
                end
            end
            3'd3: begin
                if (bv != 32'd0) begin
                    eLo = av / bv;
                    eHi = av % bv;
                end
            end
            default: ;
        endcase
    endtask

    // Launch one arithmetic op (called just after an edge with busy=0),
    // optionally pulsing start with injOp in busy cycle injCycle, and check
    // the stall request, busy length and committed result.
    task automatic applyStimulus(input logic [2:0] opc, input logic [31:0] av,
                                 input logic [31:0] bv, input logic mu,
                                 input int injCycle, input logic [2:0] injOp);
        logic [31:0] eHi;
        logic [31:0] eLo;
        int          n;
        int          cnt;
        modelOp(opc, av, bv, eHi, eLo, n);
        checkOutput("idle_before", busy, 1'b0);
        start  = 1'b1;
        op     = opc;
        a      = av;
        b      = bv;
        md_use = mu;
        #1;
        checkOutput("stall_launch", stall_req, mu);
        tick();
        cnt = 0;
        while (busy === 1'b1 && cnt < n + 4) begin
            cnt++;
            if (cnt == injCycle) begin
                start = 1'b1;
                op    = injOp;
            end else begin
                start = 1'b0;
            end
            a = $urandom;
            b = $urandom;
            #1;
            checkOutput("stall_busy", stall_req, mu);
            tick();
        end
        start = 1'b0;
        #1;
        checkOutput("busy_len", cnt, n);
        checkOutput("hi_commit", hi, eHi);
        checkOutput("lo_commit", lo, eLo);
        checkOutput("stall_after", stall_req, 1'b0);
        mHi = eHi;
        mLo = eLo;
    endtask

    // Single-cycle move or no-op, issued while idle
    task automatic applyMove(input logic [2:0] opc, input logic [31:0] av);
        start = 1'b1;
        op    = opc;
        a     = av;
        tick();
        start = 1'b0;
        if (opc == 3'd4) mHi = av;
        if (opc == 3'd5) mLo = av;
        checkOutput("move_busy", busy, 1'b0);
        checkOutput("move_hi", hi, mHi);
        checkOutput("move_lo", lo, mLo);
    endtask

    initial begin
        nChecks = 0;
        nPassed = 0;
        mHi     = 32'd0;
        mLo     = 32'd0;
        rst     = 1'b1;
        start   = 1'b1;
        op      = 3'd0;
        a       = 32'h1234;
        b       = 32'h5678;
        md_use  = 1'b1;

        // Reset held two cycles with a competing launch: reset wins
        tick();
        tick();
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        checkOutput("rst_stall_start", stall_req, 1'b1);
        start = 1'b0;
        #1;
        checkOutput("rst_stall_idle", stall_req, 1'b0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_busy", busy, 1'b0);

        // Documented mult/multu/div/divu examples
        applyStimulus(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 0, 3'd0);
        checkOutput("mult_hi_const", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo_const", lo, 32'hFFFFFFFA);
        applyStimulus(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 0, 3'd0);
        checkOutput("multu_hi_const", hi, 32'h00000002);
        checkOutput("multu_lo_const", lo, 32'hFFFFFFFA);
        applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 0, 3'd0);
        checkOutput("div_hi_const", hi, 32'hFFFFFFFF);
        checkOutput("div_lo_const", lo, 32'hFFFFFFFD);
        applyStimulus(3'd3, 32'd7, 32'd0, 1'b0, 0, 3'd0);
        checkOutput("divu0_hi_const", hi, 32'hFFFFFFFF);
        checkOutput("divu0_lo_const", lo, 32'hFFFFFFFD);

        // Signed overflow case
        applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 3'd0);
        checkOutput("ovf_lo_const", lo, 32'h80000000);
        checkOutput("ovf_hi_const", hi, 32'd0);

        // Stall handshake with a stray mult start in the middle of a div
        applyStimulus(3'd2, 32'd1000, 32'd7, 1'b1, 4, 3'd0);
        md_use = 1'b0;

        // mthi then mtlo on consecutive cycles
        start = 1'b1;
        op    = 3'd4;
        a     = 32'h12345678;
        tick();
        checkOutput("mthi_hi", hi, 32'h12345678);
        checkOutput("mthi_busy", busy, 1'b0);
        op = 3'd5;
        a  = 32'h9ABCDEF0;
        tick();
        start = 1'b0;
        checkOutput("mtlo_lo", lo, 32'h9ABCDEF0);
        checkOutput("mtlo_hi", hi, 32'h12345678);
        checkOutput("mtlo_busy", busy, 1'b0);
        mHi = 32'h12345678;
        mLo = 32'h9ABCDEF0;

        // mthi/mtlo during a divide-by-zero must leave HI/LO alone
        applyStimulus(3'd3, 32'd55, 32'd0, 1'b0, 2, 3'd4);
        applyStimulus(3'd2, 32'd55, 32'd0, 1'b0, 6, 3'd5);

        // Reset in the third busy cycle of a mult aborts it
        start = 1'b1;
        op    = 3'd0;
        a     = 32'd100;
        b     = 32'd200;
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("abort_busy_mid", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        mHi = 32'd0;
        mLo = 32'd0;
        for (int i = 0; i < 8; i++) tick();
        checkOutput("abort_nocommit_hi", hi, 32'd0);
        checkOutput("abort_nocommit_lo", lo, 32'd0);
        checkOutput("abort_nocommit_busy", busy, 1'b0);

        // Randomised mix of all opcodes
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 5));
            if (rop <= 3'd3) begin
                applyStimulus(rop, ra, rb, 1'($urandom_range(0, 1)),
                              int'($urandom_range(0, 6)),
                              3'($urandom_range(0, 7)));
                md_use = 1'b0;
            end else begin
                applyMove(rop, ra);
            end
        end

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
